// File: rtl/whack_pkg.sv
// Shared constants and types for the whack-a-mole strike arbiter.
package whack_pkg;

    localparam int HOLES          = 10;
    localparam int LOCKOUT_CYCLES = 50000000;
    localparam int HOLE_W         = 4;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              hit;
        logic              player;
        logic [HOLE_W-1:0] hole;
    } result_t;

endpackage

// File: rtl/hit_arbiter_lockout_timer.sv
// Per-player miss-penalty down-counter; compiled only when HIT_ARB_LOCKOUT_EN is defined.
`ifdef HIT_ARB_LOCKOUT_EN
module lockout_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    output logic active
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    // Loads CYCLES-1 and stays active through the terminal-count cycle,
    // so the lockout spans exactly CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= CW'(CYCLES - 1);
            active <= 1'b1;
        end else if (clr) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - CW'(1);
        end
    end
endmodule
`endif

// File: rtl/hit_arbiter.sv
// Strike buffer, round-robin arbiter, hit/miss resolver and scorekeeper.
// Miss lockout timers are built only when HIT_ARB_LOCKOUT_EN is defined.
module hit_arbiter #(
    parameter int HOLES          = whack_pkg::HOLES,
    parameter int LOCKOUT_CYCLES = whack_pkg::LOCKOUT_CYCLES,
    parameter int SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               input_valid,
    input  logic [3:0]         num,
    input  logic               player,
    input  logic [HOLES-1:0]   mole_active,
    output logic               hit_valid,
    output logic               miss_valid,
    output logic               res_player,
    output logic [3:0]         res_hole,
    output logic [HOLES-1:0]   mole_clear,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         lockout,
    output logic [7:0]         drop_cnt
);
    import whack_pkg::*;

    if (LOCKOUT_CYCLES < 1) begin : g_bad_cfg
        $error("hit_arbiter: LOCKOUT_CYCLES must be at least 1");
    end

    logic [1:0]        pend_v;
    logic [HOLE_W-1:0] pend_hole [2];
    logic              rr_ptr;
    logic              game_en_q;
    logic [HOLES-1:0]  claimed;
    result_t           res_q;

    logic              grant_v;
    logic              grant_p;
    logic [HOLE_W-1:0] grant_hole;
    logic              hit_now;
    logic              accept;
    logic              drop;
    logic              en_rise;
    logic [1:0]        miss_load;

    always_comb begin
        grant_v = game_en && (pend_v != 2'b00);
        grant_p = P0;
        if (pend_v == 2'b11) grant_p = rr_ptr;
        else if (pend_v[1])  grant_p = P1;
        grant_hole = pend_hole[grant_p];
        hit_now    = mole_active[grant_hole] && !claimed[grant_hole];
        // A slot being granted this edge frees up for a same-edge capture.
        accept = input_valid && game_en && ({1'b0, num} < 5'(HOLES)) && !lockout[player]
                 && (!pend_v[player] || (grant_v && grant_p == player));
        drop         = input_valid && !accept;
        en_rise      = game_en && !game_en_q;
        miss_load[0] = grant_v && !hit_now && (grant_p == P0);
        miss_load[1] = grant_v && !hit_now && (grant_p == P1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v       <= 2'b00;
            pend_hole[0] <= '0;
            pend_hole[1] <= '0;
        end else if (!game_en) begin
            pend_v <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (grant_v && grant_p == 1'(p)) pend_v[p] <= 1'b0;
                if (accept && player == 1'(p)) begin
                    pend_v[p]    <= 1'b1;
                    pend_hole[p] <= num;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= '0;
            mole_clear <= '0;
            claimed    <= '0;
        end else begin
            res_q.valid <= grant_v;
            res_q.hit   <= grant_v && hit_now;
            if (grant_v) begin
                res_q.player <= grant_p;
                res_q.hole   <= grant_hole;
            end
            mole_clear <= (grant_v && hit_now) ? (HOLES'(1) << grant_hole) : '0;
            claimed    <= (claimed | ((grant_v && hit_now) ? (HOLES'(1) << grant_hole) : '0))
                          & mole_active;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score0    <= '0;
            score1    <= '0;
            rr_ptr    <= P0;
            game_en_q <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            game_en_q <= game_en;
            if (en_rise) begin
                score0 <= '0;
                score1 <= '0;
                rr_ptr <= P0;
            end else begin
                if (grant_v && hit_now && grant_p == P0 && score0 != '1) score0 <= score0 + SCORE_W'(1);
                if (grant_v && hit_now && grant_p == P1 && score1 != '1) score1 <= score1 + SCORE_W'(1);
                if (grant_v && pend_v == 2'b11) rr_ptr <= ~rr_ptr;
            end
            if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign hit_valid  = res_q.valid && res_q.hit;
    assign miss_valid = res_q.valid && !res_q.hit;
    assign res_player = res_q.player;
    assign res_hole   = res_q.hole;

`ifdef HIT_ARB_LOCKOUT_EN
    for (genvar g = 0; g < 2; g++) begin : g_lock
        lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
            .clk    (clk),
            .rst    (rst),
            .clr    (!game_en),
            .load   (miss_load[g]),
            .active (lockout[g])
        );
    end
`else
    logic unused_miss_load;
    assign unused_miss_load = ^miss_load;
    assign lockout = 2'b00;
`endif

endmodule
